// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          DEFAULT_CNT_W = 32;

    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detect inputs and pipeline write-enable outputs of the scheduler.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_use_rs2_i;
    logic       id_branch_taken_i;
    logic [4:0] ex_rd_i;
    logic       ex_memread_i;
    logic       mem_req_i;
    logic       mem_ack_i;

    logic       pc_we_o;
    logic       ifid_we_o;
    logic       ifid_flush_o;
    logic       idex_bubble_o;
    logic       back_we_o;
    logic       stall_o;
    logic       flush_o;

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs2_i, id_branch_taken_i,
        input  ex_rd_i, ex_memread_i, mem_req_i, mem_ack_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
        output back_we_o, stall_o, flush_o
    );

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs2_i, id_branch_taken_i,
        output ex_rd_i, ex_memread_i, mem_req_i, mem_ack_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
        input  back_we_o, stall_o, flush_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clear_i)
            q_d = '0;
        else if (inc_i && (q_q != '1))
            q_d = q_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush scheduler: run FSM, load-use/branch priority, saturating stats.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int MAX_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    pipe_hazard_ctrl_if.slave  hz,
    output logic [1:0]         state_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o,
    output logic [CNT_W-1:0]   wait_cnt_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);

    // Budget compare is done at >=32 bits so a narrow counter never aliases MAX_CYCLES-1.
    localparam int CW = (CNT_W > 32) ? CNT_W : 32;

    state_e state_q, state_d;

    logic active;
    logic mem_wait;
    logic freeze;
    logic lu;
    logic budget_hit;
    logic [CW-1:0] cyc_ext;

    logic pc_we, ifid_we, ifid_flush, idex_bubble, back_we, stall, flush;

    assign active   = is_active(state_q);
    assign mem_wait = hz.mem_req_i & ~hz.mem_ack_i;
    assign freeze   = ~active | mem_wait;

    assign lu = hz.ex_memread_i && (hz.ex_rd_i != 5'd0) &&
                ((hz.ex_rd_i == hz.id_rs1_i) ||
                 (hz.id_use_rs2_i && (hz.ex_rd_i == hz.id_rs2_i)));

    assign cyc_ext    = CW'(cycle_cnt_o);
    assign budget_hit = (MAX_CYCLES != 0) && (cyc_ext == CW'(MAX_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (budget_hit)    state_d = ST_HALT;
                else if (!start_i) state_d = ST_IDLE;
                else if (mem_wait) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (budget_hit)          state_d = ST_HALT;
                else if (!start_i)       state_d = ST_IDLE;
                else if (hz.mem_ack_i)   state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        back_we     = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        if (!freeze) begin
            back_we = 1'b1;
            if (lu) begin
                // A taken branch here is dropped; it re-resolves once the bubble passes.
                idex_bubble = 1'b1;
                stall       = 1'b1;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
                if (hz.id_branch_taken_i) begin
                    ifid_flush = 1'b1;
                    flush      = 1'b1;
                end
            end
        end
    end

    assign hz.pc_we_o       = pc_we;
    assign hz.ifid_we_o     = ifid_we;
    assign hz.ifid_flush_o  = ifid_flush;
    assign hz.idex_bubble_o = idex_bubble;
    assign hz.back_we_o     = back_we;
    assign hz.stall_o       = stall;
    assign hz.flush_o       = flush;

    assign state_o = state_q;
    assign done_o  = (state_q == ST_HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (stall),
        .clear_i (1'b0),
        .q_o     (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush),
        .clear_i (1'b0),
        .q_o     (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (active & mem_wait),
        .clear_i (1'b0),
        .q_o     (wait_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (active),
        .clear_i (1'b0),
        .q_o     (cycle_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: budgeted instance (MAX_CYCLES=10) and a 2-bit counter instance.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;
    logic start_a, start_b;

    logic [1:0]  state_a, state_b;
    logic        done_a, done_b;
    logic [31:0] stall_a, flush_a, wait_a, cycle_a;
    logic [1:0]  stall_b, flush_b, wait_b, cycle_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pipe_hazard_ctrl_if ifa ();
    pipe_hazard_ctrl_if ifb ();

    pipe_hazard_ctrl #(.CNT_W(32), .MAX_CYCLES(10)) dut_a (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .start_i     (start_a),
        .hz          (ifa),
        .state_o     (state_a),
        .done_o      (done_a),
        .stall_cnt_o (stall_a),
        .flush_cnt_o (flush_a),
        .wait_cnt_o  (wait_a),
        .cycle_cnt_o (cycle_a)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .MAX_CYCLES(0)) dut_b (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .start_i     (start_b),
        .hz          (ifb),
        .state_o     (state_b),
        .done_o      (done_b),
        .stall_cnt_o (stall_b),
        .flush_cnt_o (flush_b),
        .wait_cnt_o  (wait_b),
        .cycle_cnt_o (cycle_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.id_rs1_i = '0; ifa.id_rs2_i = '0; ifa.id_use_rs2_i = 1'b0;
        ifa.id_branch_taken_i = 1'b0; ifa.ex_rd_i = '0; ifa.ex_memread_i = 1'b0;
        ifa.mem_req_i = 1'b0; ifa.mem_ack_i = 1'b0;
    endtask

    task automatic idle_b();
        ifb.id_rs1_i = '0; ifb.id_rs2_i = '0; ifb.id_use_rs2_i = 1'b0;
        ifb.id_branch_taken_i = 1'b0; ifb.ex_rd_i = '0; ifb.ex_memread_i = 1'b0;
        ifb.mem_req_i = 1'b0; ifb.mem_ack_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        idle_a(); idle_b();

        // Reset state
        #12;
        chk("rst_state", 32'(state_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_stall_cnt", stall_a, 0);
        chk("rst_cycle_cnt", cycle_a, 0);
        chk("rst_pc_we", 32'(ifa.pc_we_o), 0);
        chk("rst_back_we", 32'(ifa.back_we_o), 0);
        chk("rst_stall", 32'(ifa.stall_o), 0);
        #6 rst_n = 1'b1;

        // IDLE gating on start
        tick();
        chk("c0_state", 32'(state_a), 0);
        chk("c0_pc_we", 32'(ifa.pc_we_o), 0);
        tick();
        chk("c1_pc_we", 32'(ifa.pc_we_o), 0);
        start_a = 1'b1;
        #3;
        chk("c2_state", 32'(state_a), 0);
        chk("c2_pc_we", 32'(ifa.pc_we_o), 0);
        tick();
        chk("c3_state", 32'(state_a), 1);
        chk("c3_pc_we", 32'(ifa.pc_we_o), 1);
        chk("c3_cycle_cnt", cycle_a, 0);

        // Load-use via rs2
        ifa.ex_memread_i = 1'b1; ifa.ex_rd_i = 5'd5; ifa.id_rs2_i = 5'd5; ifa.id_use_rs2_i = 1'b1;
        #3;
        chk("lu_stall", 32'(ifa.stall_o), 1);
        chk("lu_bubble", 32'(ifa.idex_bubble_o), 1);
        chk("lu_pc_we", 32'(ifa.pc_we_o), 0);
        chk("lu_ifid_we", 32'(ifa.ifid_we_o), 0);
        chk("lu_back_we", 32'(ifa.back_we_o), 1);
        tick();
        chk("lu_stall_cnt", stall_a, 1);
        chk("lu_cycle_cnt", cycle_a, 1);

        // rd = x0 never stalls, even though it matches rs1/rs2 = 0
        ifa.ex_rd_i = 5'd0; ifa.id_rs2_i = 5'd0;
        #3;
        chk("x0_stall", 32'(ifa.stall_o), 0);
        chk("x0_pc_we", 32'(ifa.pc_we_o), 1);
        chk("x0_bubble", 32'(ifa.idex_bubble_o), 0);
        tick();
        chk("x0_stall_cnt", stall_a, 1);

        // Load-use via rs1 together with taken branch: stall wins
        ifa.ex_rd_i = 5'd7; ifa.id_rs1_i = 5'd7; ifa.id_use_rs2_i = 1'b0; ifa.id_branch_taken_i = 1'b1;
        #3;
        chk("lubr_stall", 32'(ifa.stall_o), 1);
        chk("lubr_flush", 32'(ifa.flush_o), 0);
        chk("lubr_ifid_flush", 32'(ifa.ifid_flush_o), 0);
        chk("lubr_pc_we", 32'(ifa.pc_we_o), 0);
        tick();
        chk("lubr_stall_cnt", stall_a, 2);
        chk("lubr_flush_cnt", flush_a, 0);

        // Branch alone
        ifa.ex_memread_i = 1'b0; ifa.ex_rd_i = '0; ifa.id_rs1_i = '0;
        #3;
        chk("br_flush", 32'(ifa.flush_o), 1);
        chk("br_ifid_flush", 32'(ifa.ifid_flush_o), 1);
        chk("br_pc_we", 32'(ifa.pc_we_o), 1);
        chk("br_ifid_we", 32'(ifa.ifid_we_o), 1);
        chk("br_back_we", 32'(ifa.back_we_o), 1);
        tick();
        chk("br_flush_cnt", flush_a, 1);
        chk("br_cycle_cnt", cycle_a, 4);

        // Memory wait: 3 frozen cycles then ack
        ifa.id_branch_taken_i = 1'b0; ifa.mem_req_i = 1'b1; ifa.mem_ack_i = 1'b0;
        #3;
        chk("mw_pc_we", 32'(ifa.pc_we_o), 0);
        chk("mw_back_we", 32'(ifa.back_we_o), 0);
        chk("mw_ifid_we", 32'(ifa.ifid_we_o), 0);
        chk("mw_state_run", 32'(state_a), 1);
        tick();
        chk("mw1_state", 32'(state_a), 2);
        chk("mw1_wait_cnt", wait_a, 1);
        #3;
        chk("mw2_back_we", 32'(ifa.back_we_o), 0);
        tick();
        chk("mw2_state", 32'(state_a), 2);
        chk("mw2_wait_cnt", wait_a, 2);
        tick();
        chk("mw3_state", 32'(state_a), 2);
        chk("mw3_wait_cnt", wait_a, 3);
        ifa.mem_ack_i = 1'b1;
        #3;
        chk("ack_pc_we", 32'(ifa.pc_we_o), 1);
        chk("ack_back_we", 32'(ifa.back_we_o), 1);
        tick();
        chk("ack_state", 32'(state_a), 1);
        chk("ack_wait_cnt", wait_a, 3);
        chk("ack_cycle_cnt", cycle_a, 8);

        // Cycle budget of 10
        idle_a();
        tick();
        chk("pre_halt_cycle_cnt", cycle_a, 9);
        chk("pre_halt_done", 32'(done_a), 0);
        tick();
        chk("halt_state", 32'(state_a), 3);
        chk("halt_done", 32'(done_a), 1);
        chk("halt_cycle_cnt", cycle_a, 10);
        ifa.ex_memread_i = 1'b1; ifa.ex_rd_i = 5'd4; ifa.id_rs1_i = 5'd4;
        #3;
        chk("halt_pc_we", 32'(ifa.pc_we_o), 0);
        chk("halt_back_we", 32'(ifa.back_we_o), 0);
        chk("halt_stall", 32'(ifa.stall_o), 0);
        tick();
        chk("halt_hold_state", 32'(state_a), 3);
        chk("halt_hold_cycle_cnt", cycle_a, 10);

        // Reset out of HALT, then same-cycle ack and start-drop from WAIT
        idle_a();
        rst_n = 1'b0;
        #3;
        chk("rst2_state", 32'(state_a), 0);
        chk("rst2_done", 32'(done_a), 0);
        chk("rst2_cycle_cnt", cycle_a, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("r2_state", 32'(state_a), 1);
        ifa.mem_req_i = 1'b1; ifa.mem_ack_i = 1'b1;
        #3;
        chk("zw_pc_we", 32'(ifa.pc_we_o), 1);
        tick();
        chk("zw_state", 32'(state_a), 1);
        chk("zw_wait_cnt", wait_a, 0);
        chk("zw_cycle_cnt", cycle_a, 1);
        ifa.mem_ack_i = 1'b0;
        #3;
        chk("w2_pc_we", 32'(ifa.pc_we_o), 0);
        tick();
        chk("w2_state", 32'(state_a), 2);
        chk("w2_wait_cnt", wait_a, 1);
        start_a = 1'b0;
        tick();
        chk("stop_state", 32'(state_a), 0);
        chk("stop_wait_cnt", wait_a, 2);
        chk("stop_cycle_cnt", cycle_a, 3);
        #3;
        chk("idle_pc_we", 32'(ifa.pc_we_o), 0);
        tick();
        chk("idle_hold_wait_cnt", wait_a, 2);
        chk("idle_hold_cycle_cnt", cycle_a, 3);
        start_a = 1'b1;
        tick();
        chk("restart_state", 32'(state_a), 1);
        chk("restart_cycle_cnt", cycle_a, 3);
        tick();
        chk("w3_state", 32'(state_a), 2);
        chk("w3_wait_cnt", wait_a, 3);
        chk("w3_cycle_cnt", cycle_a, 4);

        // Asynchronous reset mid-WAIT
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_a), 0);
        chk("arst_wait_cnt", wait_a, 0);
        chk("arst_cycle_cnt", cycle_a, 0);
        chk("arst_stall_cnt", stall_a, 0);
        chk("arst_pc_we", 32'(ifa.pc_we_o), 0);
        #2 rst_n = 1'b1;
        start_a = 1'b0;
        idle_a();

        // 2-bit counters saturate; MAX_CYCLES=0 never halts
        start_b = 1'b1;
        tick();
        chk("b_state", 32'(state_b), 1);
        for (int i = 0; i < 5; i++) begin
            ifb.ex_memread_i = 1'b1; ifb.ex_rd_i = 5'd3; ifb.id_rs1_i = 5'd3;
            #3;
            chk("b_stall", 32'(ifb.stall_o), 1);
            tick();
            chk("b_stall_cnt", 32'(stall_b), 32'(sat_exp[i]));
            ifb.ex_memread_i = 1'b0;
            tick();
        end
        chk("b_no_halt_state", 32'(state_b), 1);
        chk("b_cycle_sat", 32'(cycle_b), 3);
        chk("b_done", 32'(done_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
